// File: rtl/lmem_pkg.sv
// lmem_pkg: shared types and default widths for the layer-memory arbiter.
//   lmem_state_e : arbiter ownership state (IDLE / LOCK0 / LOCK1)
//   rid_t        : requester id (0 = conv engine, 1 = host/debug)
package lmem_pkg;

  localparam int LMEM_AW = 12;
  localparam int LMEM_DW = 20;
  localparam int LMEM_SW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lmem_state_e;

  typedef logic rid_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of {valid, id} tags for reads in flight.
//   push/push_id : tag entered on the edge that issues crd
//   pop/pop_id   : tag whose memory data is on cdata_rd now (sample this edge)
module rd_tag_pipe
  import lmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rid_t push_id,
  output logic pop,
  output rid_t pop_id
);

  logic [RD_LAT:1] vld_pipe;
  logic [RD_LAT:1] id_pipe;

  // Reset flushes every in-flight tag so no rvalid can appear after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= push;
      id_pipe[1]  <= push_id;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign pop    = vld_pipe[RD_LAT];
  assign pop_id = id_pipe[RD_LAT];

endmodule

// File: rtl/lmem_arbiter.sv
// lmem_arbiter: shares the single layer-memory bus between the conv engine
// (r0) and the host read-back/debug port (r1). One accept per cycle,
// round-robin on ties, optional bus lock for multi-access sequences, read
// data routed back to the issuer after RD_LAT cycles.
//   rN_req/we/sel/addr/wdata/lock : request fields, held stable until gnt
//   rN_gnt                        : combinational accept
//   rN_rvalid/rN_rdata            : registered read return
//   cwr/crd/caddr_wr/caddr_rd/cdata_wr/csel : registered memory command
//   cdata_rd                      : memory read data
module lmem_arbiter
  import lmem_pkg::*;
#(
  parameter int AW     = LMEM_AW,
  parameter int DW     = LMEM_DW,
  parameter int SW     = LMEM_SW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [SW-1:0] r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [SW-1:0] r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          cwr,
  output logic          crd,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  output logic [SW-1:0] csel,
  input  logic [DW-1:0] cdata_rd
);

  lmem_state_e   state;
  logic          rr;
  logic          acc;
  rid_t          aid;
  logic          a_we, a_lock;
  logic [SW-1:0] a_sel;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          pop;
  rid_t          pop_id;

  // Grants already include req, so gnt alone identifies the accepted port.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    case (state)
      LOCK0:   r0_gnt = r0_req;
      LOCK1:   r1_gnt = r1_req;
      default: begin
        r0_gnt = r0_req & (~r1_req | ~rr);
        r1_gnt = r1_req & (~r0_req |  rr);
      end
    endcase
  end

  assign acc     = r0_gnt | r1_gnt;
  assign aid     = r1_gnt;
  assign a_we    = aid ? r1_we    : r0_we;
  assign a_lock  = aid ? r1_lock  : r0_lock;
  assign a_sel   = aid ? r1_sel   : r0_sel;
  assign a_addr  = aid ? r1_addr  : r0_addr;
  assign a_wdata = aid ? r1_wdata : r0_wdata;

  // rr <= ~aid on every accept: inside LOCKn the winner is always n, so rr
  // already reads ~n and the unlocking accept leaves it pointing at the other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else if (acc) begin
      rr    <= ~aid;
      state <= a_lock ? (aid ? LOCK1 : LOCK0) : IDLE;
    end
  end

  // Memory command registers; address/data/sel hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      csel     <= '0;
    end else begin
      cwr <= acc &  a_we;
      crd <= acc & ~a_we;
      if (acc) begin
        csel <= a_sel;
        if (a_we) begin
          caddr_wr <= a_addr;
          cdata_wr <= a_wdata;
        end else begin
          caddr_rd <= a_addr;
        end
      end
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag (
    .clk     (clk),
    .reset   (reset),
    .push    (acc & ~a_we),
    .push_id (aid),
    .pop     (pop),
    .pop_id  (pop_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= pop & ~pop_id;
      r1_rvalid <= pop &  pop_id;
      if (pop & ~pop_id) r0_rdata <= cdata_rd;
      if (pop &  pop_id) r1_rdata <= cdata_rd;
    end
  end

endmodule
